seg7_scan_controller: RTL and testbench

Time-multiplexed scan controller for an 8-digit 7-segment display. It shares one BCD_TO_7SEG_EN decoder across eight common-anode digits. It holds an 8-digit BCD value and presents one digit at a time to the decoder. Each digit is shown for a fixed dwell, followed by an all-off guard gap. A valid/ready load port updates the value without tearing, because updates apply only at frame boundaries.

---
 rtl/seg7_scan_controller.sv | 173 +++++++++++++++++
 tb/tb_seg7_scan_controller.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed scan of an 8-digit common-anode 7-segment display through one shared decoder.
// Optional leading-zero blanking is compiled in when SEG7_LZB_EN is defined.
module seg7_scan_controller #(
    parameter int unsigned CLK_DIV    = 100_000,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        seg7all_on,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] bcd_in,
    output logic [3:0]  bcd_out,
    output logic        dec_enable,
    output logic        dec_all_on,
    output logic [7:0]  digit_sel,
    output logic        frame_done
);

    localparam int unsigned TICK_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int unsigned TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam logic [TICK_W-1:0] DWELL_LAST = TICK_W'(CLK_DIV - 1);
    localparam logic [TICK_W-1:0] GAP_LAST   = TICK_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [31:0]       active_q, active_d;
    logic [31:0]       pending_q, pending_d;
    logic              pend_q, pend_d;

    logic              load_ready_q, load_ready_d;
    logic [3:0]        bcd_out_q, bcd_out_d;
    logic [7:0]        digit_sel_q, digit_sel_d;
    logic              dec_enable_q, dec_enable_d;
    logic              dec_all_on_q, dec_all_on_d;
    logic              frame_done_q, frame_done_d;

    logic              transfer;
    logic              frame_end;
    logic              apply_pend;
    logic              lit;
`ifdef SEG7_LZB_EN
    logic [2:0]        msd;
`endif

    // Copy decisions use the pend flag as it stood before this cycle's transfer.
    assign transfer   = load_valid && !pend_q;
    assign frame_end  = enable && (state_q == ST_GAP) && (tick_q == GAP_LAST) && (idx_q == 3'd7);
    assign apply_pend = pend_q && enable && ((state_q == ST_OFF) || frame_end);

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_OFF;
            idx_q        <= 3'd0;
            tick_q       <= '0;
            active_q     <= 32'd0;
            pending_q    <= 32'd0;
            pend_q       <= 1'b0;
            load_ready_q <= 1'b1;
            bcd_out_q    <= 4'd0;
            digit_sel_q  <= 8'd0;
            dec_enable_q <= 1'b0;
            dec_all_on_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            tick_q       <= tick_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            pend_q       <= pend_d;
            load_ready_q <= load_ready_d;
            bcd_out_q    <= bcd_out_d;
            digit_sel_q  <= digit_sel_d;
            dec_enable_q <= dec_enable_d;
            dec_all_on_q <= dec_all_on_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state: dwell/gap sequencing over the eight digits.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tick_d  = tick_q;
        if (!enable) begin
            state_d = ST_OFF;
            idx_d   = 3'd0;
            tick_d  = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_SHOW;
                    idx_d   = 3'd0;
                    tick_d  = '0;
                end
                ST_SHOW: begin
                    if (tick_q == DWELL_LAST) begin
                        state_d = ST_GAP;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                ST_GAP: begin
                    if (tick_q == GAP_LAST) begin
                        state_d = ST_SHOW;
                        tick_d  = '0;
                        idx_d   = idx_q + 3'd1;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    idx_d   = 3'd0;
                    tick_d  = '0;
                end
            endcase
        end
    end

    // Load buffer and registered outputs, computed from next-cycle state.
    always_comb begin
        active_d     = apply_pend ? pending_q : active_q;
        pending_d    = transfer ? bcd_in : pending_q;
        pend_d       = pend_q;
        if (transfer) begin
            pend_d = 1'b1;
        end else if (apply_pend) begin
            pend_d = 1'b0;
        end
        load_ready_d = ~pend_d;
        dec_enable_d = enable;
        dec_all_on_d = seg7all_on;
        frame_done_d = frame_end;
        digit_sel_d  = 8'd0;
        bcd_out_d    = bcd_out_q;
        lit          = 1'b1;
`ifdef SEG7_LZB_EN
        msd = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (active_d[i*4 +: 4] != 4'h0) begin
                msd = 3'(i);
            end
        end
        lit = seg7all_on || (idx_d <= msd);
`endif
        if (state_d == ST_SHOW) begin
            bcd_out_d = active_d[{idx_d, 2'b00} +: 4];
            if (lit) begin
                digit_sel_d = 8'(1) << idx_d;
            end
        end
    end

    assign load_ready = load_ready_q;
    assign bcd_out    = bcd_out_q;
    assign digit_sel  = digit_sel_q;
    assign dec_enable = dec_enable_q;
    assign dec_all_on = dec_all_on_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Scoreboard bench for seg7_scan_controller (CLK_DIV=4, GAP_CYCLES=2, 48-cycle frame).
// Define SEG7_LZB_EN for both files to exercise leading-zero blanking.
module tb_seg7_scan_controller;

    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned GAP_CYCLES = 2;
    localparam int          FRAME      = 48;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        seg7all_on = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] bcd_in = 32'd0;
    logic        load_ready;
    logic [3:0]  bcd_out;
    logic        dec_enable;
    logic        dec_all_on;
    logic [7:0]  digit_sel;
    logic        frame_done;

    seg7_scan_controller #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .seg7all_on (seg7all_on),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .bcd_in     (bcd_in),
        .bcd_out    (bcd_out),
        .dec_enable (dec_enable),
        .dec_all_on (dec_all_on),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] sel;
        logic [3:0] bcd;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    bit         mon_on = 1'b0;
    logic [7:0] mon_prev = 8'd0;
    int         mon_run = 0;
    int         mon_zrun = 0;
    bit         mon_have_prev = 1'b0;
    exp_t       mon_exp;

    // Expected display scan: each lit digit pops one entry; dwell and gap lengths are checked.
    always begin
        @(posedge clock);
        #1;
        if (!mon_on) begin
            mon_have_prev = 1'b0;
            mon_run       = 0;
            mon_zrun      = 0;
        end else begin
            checks++;
            if ($countones(digit_sel) > 1) begin
                failures++;
                $display("FAIL scan_onehot got=%h exp=at most one bit", digit_sel);
            end
            if (digit_sel != 8'd0) begin
                if (mon_prev == 8'd0) begin
                    if (mon_have_prev) begin
                        checks++;
                        if (mon_zrun < int'(GAP_CYCLES)) begin
                            failures++;
                            $display("FAIL scan_gap got=%0d exp>=%0d", mon_zrun, GAP_CYCLES);
                        end
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL scan_extra got sel=%h bcd=%h exp=no digit", digit_sel, bcd_out);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (digit_sel !== mon_exp.sel || bcd_out !== mon_exp.bcd) begin
                            failures++;
                            $display("FAIL scan_digit got sel=%h bcd=%h exp sel=%h bcd=%h",
                                     digit_sel, bcd_out, mon_exp.sel, mon_exp.bcd);
                        end
                    end
                    mon_run = 1;
                end else begin
                    if (digit_sel !== mon_prev) begin
                        failures++;
                        $display("FAIL scan_nogap got=%h exp=%h", digit_sel, mon_prev);
                    end
                    mon_run++;
                end
                mon_zrun = 0;
            end else begin
                if (mon_prev != 8'd0) begin
                    checks++;
                    if (mon_run != int'(CLK_DIV)) begin
                        failures++;
                        $display("FAIL scan_dwell got=%0d exp=%0d", mon_run, CLK_DIV);
                    end
                    mon_have_prev = 1'b1;
                end
                mon_zrun++;
            end
        end
        mon_prev = digit_sel;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int msd(input logic [31:0] v);
        int m = 0;
        for (int i = 1; i < 8; i++) if (v[i*4 +: 4] != 4'h0) m = i;
        return m;
    endfunction

    task automatic push_digits(input logic [31:0] v, input bit all, input int lo, input int hi);
        exp_t e;
        bit   lzb;
        int   m;
        m = msd(v);
`ifdef SEG7_LZB_EN
        lzb = !all;
`else
        lzb = 1'b0;
`endif
        for (int i = lo; i <= hi; i++) begin
            if (!lzb || i <= m) begin
                e.sel = 8'h01 << i;
                e.bcd = v[i*4 +: 4];
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_fd(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            n++;
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_sel(input logic [7:0] s, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (digit_sel === s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_load(input logic [31:0] v);
        load_valid = 1'b1;
        bcd_in     = v;
        @(negedge clock);
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({load_ready, bcd_out, digit_sel, dec_enable, dec_all_on, frame_done} !== 16'h8000) begin
            failures++;
            $display("FAIL reset_values got=%h exp=8000",
                     {load_ready, bcd_out, digit_sel, dec_enable, dec_all_on, frame_done});
        end
        enable  = 1'b0;
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        checks++;
        if (digit_sel !== 8'h00 || dec_enable !== 1'b0 || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_off got sel=%h en=%b rdy=%b exp sel=00 en=0 rdy=1",
                     digit_sel, dec_enable, load_ready);
        end
    endtask

    task automatic test_scan();
        int n;
        bit ok;
        push_digits(32'h0, 1'b1, 0, 7);
        push_digits(32'h0, 1'b1, 0, 7);
        mon_on = 1'b1;
        enable = 1'b1;
        @(negedge clock);
        checks++;
        if (digit_sel !== 8'h01 || dec_enable !== 1'b1) begin
            failures++;
            $display("FAIL first_show got sel=%h en=%b exp sel=01 en=1", digit_sel, dec_enable);
        end
        wait_fd(n, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL scan_fd1 got=timeout exp=frame_done"); end
        push_digits(32'h0, 1'b1, 0, 7);
        wait_fd(n, ok);
        checks++;
        if (!ok || n != FRAME) begin
            failures++;
            $display("FAIL frame_len got=%0d exp=%0d", n, FRAME);
        end
        @(negedge clock);
        checks++;
        if (frame_done !== 1'b0 || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL fd_pulse got fd=%b rdy=%b exp fd=0 rdy=1", frame_done, load_ready);
        end
    endtask

    task automatic test_load();
        int n;
        bit ok;
        push_digits(32'h8765_4321, 1'b1, 0, 7);
        repeat (10) @(negedge clock);
        pulse_load(32'h8765_4321);
        checks++;
        if (load_ready !== 1'b0) begin failures++; $display("FAIL load_ready_fall got=%b exp=0", load_ready); end
        wait_fd(n, ok);
        checks++;
        if (!ok || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_ready_rise got ok=%b rdy=%b exp ok=1 rdy=1", ok, load_ready);
        end
        push_digits(32'h8765_4321, 1'b1, 0, 7);
    endtask

    task automatic test_back_to_back();
        int n;
        bit ok;
        int stall_bad;
        wait_fd(n, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_fd got=timeout exp=frame_done"); end
        push_digits(32'h1357_2468, 1'b1, 0, 7);
        repeat (10) @(negedge clock);
        load_valid = 1'b1;
        bcd_in     = 32'h1357_2468;
        @(negedge clock);
        bcd_in = 32'h9ABC_DEF0;
        checks++;
        if (load_ready !== 1'b0) begin failures++; $display("FAIL b2b_a_taken got=%b exp=0", load_ready); end
        stall_bad = 0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (load_ready !== 1'b0) stall_bad++;
        end
        checks++;
        if (!ok || stall_bad != 0) begin
            failures++;
            $display("FAIL b2b_stall got ok=%b early_ready=%0d exp ok=1 early_ready=0", ok, stall_bad);
        end
        checks++;
        if (load_ready !== 1'b1) begin failures++; $display("FAIL b2b_boundary_ready got=%b exp=1", load_ready); end
        push_digits(32'h9ABC_DEF0, 1'b1, 0, 7);
        @(negedge clock);
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0) begin failures++; $display("FAIL b2b_b_taken got=%b exp=0", load_ready); end
    endtask

    task automatic test_boundary_load();
        int n;
        bit ok;
        wait_fd(n, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL bnd_fd got=timeout exp=frame_done"); end
        push_digits(32'h9ABC_DEF0, 1'b1, 0, 7);
        repeat (FRAME - 1) @(negedge clock);
        load_valid = 1'b1;
        bcd_in     = 32'h2468_1357;
        @(negedge clock);
        load_valid = 1'b0;
        checks++;
        if (frame_done !== 1'b1 || load_ready !== 1'b0) begin
            failures++;
            $display("FAIL bnd_same_cycle got fd=%b rdy=%b exp fd=1 rdy=0", frame_done, load_ready);
        end
        push_digits(32'h2468_1357, 1'b1, 0, 7);
        wait_fd(n, ok);
        checks++;
        if (!ok || n != FRAME) begin failures++; $display("FAIL bnd_frame_len got=%0d exp=%0d", n, FRAME); end
    endtask

    task automatic test_enable();
        int n;
        bit ok;
        int lit_cnt;
        wait_sel(8'h04, ok);
        wait_sel(8'h00, ok);
        mon_on = 1'b0;
        checks++;
        if (!ok || exp_q.size() != 5) begin
            failures++;
            $display("FAIL en_queue got=%0d exp=5", exp_q.size());
        end
        exp_q.delete();
        wait_sel(8'h08, ok);
        @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        checks++;
        if (digit_sel !== 8'h00 || dec_enable !== 1'b0) begin
            failures++;
            $display("FAIL en_drop got sel=%h en=%b exp sel=00 en=0", digit_sel, dec_enable);
        end
        lit_cnt = 0;
        repeat (6) begin
            @(negedge clock);
            if (digit_sel !== 8'h00) lit_cnt++;
        end
        checks++;
        if (lit_cnt != 0) begin failures++; $display("FAIL en_dark got=%0d exp=0", lit_cnt); end
        push_digits(32'h2468_1357, 1'b1, 0, 7);
        push_digits(32'h2468_1357, 1'b1, 0, 7);
        mon_on = 1'b1;
        enable = 1'b1;
        @(negedge clock);
        checks++;
        if (digit_sel !== 8'h01 || bcd_out !== 4'h7) begin
            failures++;
            $display("FAIL en_restart got sel=%h bcd=%h exp sel=01 bcd=7", digit_sel, bcd_out);
        end
        wait_fd(n, ok);
        wait_sel(8'h00, ok);
        mon_on = 1'b0;
        checks++;
        if (exp_q.size() != 7) begin failures++; $display("FAIL en_tail got=%0d exp=7", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int n;
        bit ok;
        wait_sel(8'h10, ok);
        pulse_load(32'h5555_5555);
        checks++;
        if (load_ready !== 1'b0) begin failures++; $display("FAIL rst_pre_load got=%b exp=0", load_ready); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({load_ready, bcd_out, digit_sel, dec_enable, dec_all_on, frame_done} !== 16'h8000) begin
            failures++;
            $display("FAIL rst_async got=%h exp=8000",
                     {load_ready, bcd_out, digit_sel, dec_enable, dec_all_on, frame_done});
        end
        @(negedge clock);
        push_digits(32'h0, 1'b1, 0, 7);
        push_digits(32'h0, 1'b1, 0, 7);
        mon_on  = 1'b1;
        reset_n = 1'b1;
        wait_fd(n, ok);
        checks++;
        if (!ok || n != FRAME + 1) begin failures++; $display("FAIL rst_restart got=%0d exp=%0d", n, FRAME + 1); end
        wait_sel(8'h00, ok);
        mon_on = 1'b0;
        checks++;
        if (exp_q.size() != 7) begin failures++; $display("FAIL rst_tail got=%0d exp=7", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_lzb_all_on();
        int n;
        bit ok;
        pulse_load(32'h0000_0120);
        wait_fd(n, ok);
        wait_sel(8'h00, ok);
        push_digits(32'h0000_0120, 1'b0, 1, 7);
        push_digits(32'h0000_0120, 1'b0, 0, 7);
        mon_on = 1'b1;
        wait_fd(n, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL lzb_fd got=timeout exp=frame_done"); end
        push_digits(32'h0000_0120, 1'b0, 0, 0);
        wait_fd(n, ok);
        checks++;
        if (!ok || n != FRAME) begin failures++; $display("FAIL lzb_frame_len got=%0d exp=%0d", n, FRAME); end
        seg7all_on = 1'b1;
        push_digits(32'h0000_0120, 1'b1, 1, 7);
        push_digits(32'h0000_0120, 1'b1, 0, 7);
        @(negedge clock);
        checks++;
        if (dec_all_on !== 1'b1) begin failures++; $display("FAIL all_on_fwd got=%b exp=1", dec_all_on); end
        wait_fd(n, ok);
        wait_sel(8'h00, ok);
        mon_on = 1'b0;
        checks++;
        if (exp_q.size() != 7) begin failures++; $display("FAIL all_on_tail got=%0d exp=7", exp_q.size()); end
        exp_q.delete();
        seg7all_on = 1'b0;
        @(negedge clock);
        checks++;
        if (dec_all_on !== 1'b0) begin failures++; $display("FAIL all_on_clear got=%b exp=0", dec_all_on); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_back_to_back();
        test_boundary_load();
        test_enable();
        test_reset_mid();
        test_lzb_all_on();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
